// File: rtl/sram_stream_reader.sv
// Burst reader: async SRAM words from a PIO base pointer into a valid/ready FIFO.
// Optional SRAM_RD_ABORT_EN adds an abort input that cancels a burst and flushes the FIFO.
module sram_stream_reader #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int BURST_LEN   = 64,
  parameter int WAIT_CYCLES = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef SRAM_RD_ABORT_EN
  input  logic              abort,
`endif
  input  logic [ADDR_W-1:0] base_ptr,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic             push;
  logic             pop;
  logic             flush;
  logic             abort_req;
  logic [FC_W-1:0]  fill_after;

`ifdef SRAM_RD_ABORT_EN
  assign abort_req = abort && (state_q != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign rd_valid   = (fcnt_q != '0);
  assign pop        = rd_valid && rd_ready;
  assign fill_after = fcnt_q + FC_W'(1) - FC_W'(pop);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_ptr;
          cnt_d   = '0;
          wait_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (wait_q == WC_W'(WAIT_CYCLES)) begin
          push   = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          wait_d = '0;
          if (cnt_d == CNT_W'(BURST_LEN)) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (fill_after == FC_W'(FIFO_DEPTH))
              state_d = HOLD;
          end
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      HOLD: begin
        if (fcnt_q != FC_W'(FIFO_DEPTH) || pop) begin
          wait_d  = '0;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_req) begin
      state_d = IDLE;
      cnt_d   = '0;
      wait_d  = '0;
      push    = 1'b0;
      flush   = 1'b1;
    end
  end

  always_comb begin
    fcnt_d   = fcnt_q + FC_W'(push) - FC_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    if (flush) begin
      fcnt_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      fcnt_q   <= fcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: rd_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= sram_dq_in;
  end

  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sram_addr = addr_q;
  assign sram_ce_n = (state_q != READ);
  assign sram_oe_n = (state_q != READ);
  assign sram_ub_n = (state_q != READ);
  assign sram_lb_n = (state_q != READ);
  assign sram_we_n = 1'b1;

endmodule
